// File: rtl/axis_packet_framer.sv
// rtl/axis_packet_framer.sv - wraps each upstream packet in a header beat and a trailer beat
// Header = {MAGIC, seq}; trailer = {xor16 of payload, payload beat count}; payload passes through combinationally.
module axis_packet_framer #(
  parameter int          AXIS_TDATA_WIDTH = 32,
  parameter logic [15:0] MAGIC            = 16'hA55A,
  parameter int          SEQ_WIDTH        = 16
) (
  input  logic                        axis_aclk,
  input  logic                        axis_aresetn,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [SEQ_WIDTH-1:0]        seq_out,
  output logic                        len_sat_out
);

  typedef enum logic [1:0] {ST_HDR, ST_PAY, ST_TRL} state_t;

  state_t                r_state;
  logic [SEQ_WIDTH-1:0]  r_seq;
  logic [15:0]           r_beat_cnt;
  logic [15:0]           r_xor_acc;
  logic                  r_len_sat;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [15:0]           w_seq_ext;

  assign w_seq_ext   = 16'(r_seq);
  assign w_in_fire   = s_axis_tvalid & s_axis_tready;
  assign w_out_fire  = m_axis_tvalid & m_axis_tready;
  assign seq_out     = r_seq;
  assign len_sat_out = r_len_sat;

  // Outputs are gated by reset directly so a mid-packet reset drops valid at once.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    if (axis_aresetn) begin
      case (r_state)
        ST_HDR: begin
          m_axis_tvalid       = s_axis_tvalid;
          m_axis_tdata[31:0]  = {MAGIC, w_seq_ext};
        end
        ST_PAY: begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata  = s_axis_tdata;
        end
        ST_TRL: begin
          m_axis_tvalid       = 1'b1;
          m_axis_tlast        = 1'b1;
          m_axis_tdata[31:0]  = {r_xor_acc, r_beat_cnt};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state    <= ST_HDR;
      r_seq      <= '0;
      r_beat_cnt <= '0;
      r_xor_acc  <= '0;
      r_len_sat  <= 1'b0;
    end else begin
      case (r_state)
        ST_HDR: begin
          if (w_out_fire) begin
            r_beat_cnt <= '0;
            r_xor_acc  <= '0;
            r_state    <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (w_in_fire) begin
            // Count sticks at 0xFFFF; the overflow is reported through the sticky flag.
            if (r_beat_cnt == 16'hFFFF) r_len_sat <= 1'b1;
            else                        r_beat_cnt <= r_beat_cnt + 16'd1;
            r_xor_acc <= r_xor_acc ^ s_axis_tdata[15:0];
            if (s_axis_tlast) r_state <= ST_TRL;
          end
        end
        ST_TRL: begin
          if (w_out_fire) begin
            r_seq   <= r_seq + SEQ_WIDTH'(1);
            r_state <= ST_HDR;
          end
        end
        default: r_state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_framer.sv
// tb/tb_axis_packet_framer.sv - directed self-checking bench for axis_packet_framer
// A 16-bit-seq instance and a 2-bit-seq instance share the same stimulus.
`timescale 1ns/1ps
module tb_axis_packet_framer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_tready, s_tready2;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        m_tready;
  logic [31:0] m_tdata, m_tdata2;
  logic        m_tvalid, m_tvalid2;
  logic        m_tlast, m_tlast2;
  logic [15:0] seq_o;
  logic [1:0]  seq_o2;
  logic        sat_o, sat_o2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] up_data[$];
  logic        up_last[$];
  logic [31:0] od[$];
  logic        ol[$];
  logic        osr[$];
  logic [31:0] od2[$];
  int          stab_err;

  always #5 clk = ~clk;

  axis_packet_framer #(.AXIS_TDATA_WIDTH(32), .MAGIC(16'hA55A), .SEQ_WIDTH(16)) dut (
    .axis_aclk(clk), .axis_aresetn(rstn),
    .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .seq_out(seq_o), .len_sat_out(sat_o)
  );

  axis_packet_framer #(.AXIS_TDATA_WIDTH(32), .MAGIC(16'hA55A), .SEQ_WIDTH(2)) dut2 (
    .axis_aclk(clk), .axis_aresetn(rstn),
    .s_axis_tready(s_tready2), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tlast(m_tlast2),
    .seq_out(seq_o2), .len_sat_out(sat_o2)
  );

  function automatic logic [31:0] od_at(int i);
    return (i < od.size()) ? od[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic ol_at(int i);
    return (i < ol.size()) ? ol[i] : 1'bx;
  endfunction
  function automatic logic osr_at(int i);
    return (i < osr.size()) ? osr[i] : 1'bx;
  endfunction
  function automatic logic [31:0] od2_at(int i);
    return (i < od2.size()) ? od2[i] : 32'hxxxxxxxx;
  endfunction

  task automatic clear_q();
    up_data.delete(); up_last.delete();
    od.delete(); ol.delete(); osr.delete(); od2.delete();
    stab_err = 0;
  endtask

  task automatic push_pkt(input logic [31:0] d[], input int n);
    for (int i = 0; i < n; i++) begin
      up_data.push_back(d[i]);
      up_last.push_back(i == n - 1);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Cycle-stepped driver/collector; entered and left at posedge+1.
  task automatic run(input int n_out, input bit rnd, input int budget);
    int          got = 0;
    int          cyc = 0;
    int          idx = 0;
    logic        pv  = 1'b0;
    logic [31:0] pd  = '0;
    logic        pl  = 1'b0;
    while (got < n_out && cyc < budget) begin
      if (idx < up_data.size()) begin
        s_tvalid = 1'b1; s_tdata = up_data[idx]; s_tlast = up_last[idx];
      end else begin
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
      end
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (pv && !(m_tvalid && m_tdata == pd && m_tlast == pl)) stab_err++;
      pv = m_tvalid && !m_tready; pd = m_tdata; pl = m_tlast;
      if (m_tvalid && m_tready) begin
        od.push_back(m_tdata); ol.push_back(m_tlast); osr.push_back(s_tready); got++;
      end
      if (m_tvalid2 && m_tready) od2.push_back(m_tdata2);
      if (s_tvalid && s_tready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    up_data.delete(); up_last.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hDEADBEEF; m_tready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL reset m_tvalid: got %b expected 0", m_tvalid); else n_pass++;
    n_checks++; if (s_tready !== 1'b0) $display("FAIL reset s_tready: got %b expected 0", s_tready); else n_pass++;
    n_checks++; if (m_tlast !== 1'b0) $display("FAIL reset m_tlast: got %b expected 0", m_tlast); else n_pass++;
    n_checks++; if (seq_o !== 16'd0) $display("FAIL reset seq: got %h expected 0000", seq_o); else n_pass++;
    n_checks++; if (sat_o !== 1'b0) $display("FAIL reset len_sat: got %b expected 0", sat_o); else n_pass++;
    do_reset();
  endtask

  task automatic test_basic();
    logic [31:0] pk[] = '{32'h11, 32'h22, 32'h33};
    logic [31:0] ex[] = '{32'hA55A0000, 32'h11, 32'h22, 32'h33, 32'h00000003};
    do_reset(); clear_q();
    push_pkt(pk, 3);
    run(5, 1'b0, 50);
    n_checks++; if (od.size() !== 5) $display("FAIL basic count: got %0d expected 5", od.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (od_at(i) !== ex[i]) $display("FAIL basic beat%0d: got %h expected %h", i, od_at(i), ex[i]); else n_pass++;
      n_checks++; if (ol_at(i) !== (i == 4)) $display("FAIL basic tlast%0d: got %b expected %b", i, ol_at(i), i == 4); else n_pass++;
    end
    n_checks++; if (seq_o !== 16'd1) $display("FAIL basic seq_after: got %h expected 0001", seq_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] p1[] = '{32'h1234};
    logic [31:0] p2[] = '{32'h00FF};
    logic [31:0] ex[] = '{32'hA55A0000, 32'h1234, 32'h12340001, 32'hA55A0001, 32'h00FF, 32'h00FF0001};
    do_reset(); clear_q();
    push_pkt(p1, 1); push_pkt(p2, 1);
    run(6, 1'b0, 50);
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (od_at(i) !== ex[i]) $display("FAIL b2b beat%0d: got %h expected %h", i, od_at(i), ex[i]); else n_pass++;
      if (i != 1 && i != 4) begin
        n_checks++; if (osr_at(i) !== 1'b0) $display("FAIL b2b s_tready%0d: got %b expected 0", i, osr_at(i)); else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] pk[];
    logic [15:0] x = '0;
    logic        bad = 1'b0;
    pk = new[256];
    for (int i = 0; i < 256; i++) begin
      pk[i] = 32'hC0DE0000 + 32'(i) * 32'h00010003;
      x ^= pk[i][15:0];
    end
    do_reset(); clear_q();
    push_pkt(pk, 256);
    run(258, 1'b1, 5000);
    n_checks++; if (od.size() !== 258) $display("FAIL stall count: got %0d expected 258", od.size()); else n_pass++;
    n_checks++; if (stab_err !== 0) $display("FAIL stall stability: got %0d unstable beats expected 0", stab_err); else n_pass++;
    for (int i = 0; i < 256; i++) if (od_at(i + 1) !== pk[i]) bad = 1'b1;
    n_checks++; if (bad !== 1'b0) $display("FAIL stall payload: got corrupted=%b expected 0", bad); else n_pass++;
    n_checks++; if (od_at(257) !== {x, 16'h0100}) $display("FAIL stall trailer: got %h expected %h", od_at(257), {x, 16'h0100}); else n_pass++;
  endtask

  task automatic test_seq_wrap();
    logic [31:0] p[] = '{32'h0};
    do_reset(); clear_q();
    for (int k = 0; k < 5; k++) begin
      p[0] = 32'h100 + 32'(k);
      push_pkt(p, 1);
    end
    run(15, 1'b0, 100);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (od2_at(3 * k) !== (32'hA55A0000 | 32'(k % 4)))
        $display("FAIL seqwrap hdr%0d: got %h expected %h", k, od2_at(3 * k), 32'hA55A0000 | 32'(k % 4));
      else n_pass++;
    end
    n_checks++; if (seq_o2 !== 2'd1) $display("FAIL seqwrap seq_out: got %0d expected 1", seq_o2); else n_pass++;
  endtask

  task automatic test_len_sat();
    logic [31:0] pk[];
    logic [31:0] p2[] = '{32'hABCD};
    logic [15:0] x = '0;
    pk = new[65537];
    for (int i = 0; i < 65537; i++) begin
      pk[i] = 32'(i) ^ 32'h5A00_0000;
      x ^= pk[i][15:0];
    end
    do_reset(); clear_q();
    push_pkt(pk, 65537);
    run(65539, 1'b0, 66000);
    n_checks++; if (od.size() !== 65539) $display("FAIL lensat count: got %0d expected 65539", od.size()); else n_pass++;
    n_checks++; if (od_at(65538) !== {x, 16'hFFFF}) $display("FAIL lensat trailer: got %h expected %h", od_at(65538), {x, 16'hFFFF}); else n_pass++;
    n_checks++; if (sat_o !== 1'b1) $display("FAIL lensat flag: got %b expected 1", sat_o); else n_pass++;
    clear_q();
    push_pkt(p2, 1);
    run(3, 1'b0, 50);
    n_checks++; if (od_at(0) !== 32'hA55A0001) $display("FAIL lensat next_hdr: got %h expected A55A0001", od_at(0)); else n_pass++;
    n_checks++; if (od_at(2) !== 32'hABCD0001) $display("FAIL lensat next_trl: got %h expected ABCD0001", od_at(2)); else n_pass++;
    n_checks++; if (sat_o !== 1'b1) $display("FAIL lensat sticky: got %b expected 1", sat_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] pk[] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    logic [31:0] p2[] = '{32'h5, 32'h6};
    logic [31:0] ex[] = '{32'hA55A0000, 32'h5, 32'h6, 32'h00030002};
    clear_q();
    push_pkt(pk, 4);
    run(2, 1'b0, 50);
    s_tvalid = 1'b1; s_tdata = 32'hA2; s_tlast = 1'b0; m_tready = 1'b1;
    #2;
    n_checks++; if (m_tvalid !== 1'b1) $display("FAIL rstmid pre_valid: got %b expected 1", m_tvalid); else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL rstmid valid_drop: got %b expected 0", m_tvalid); else n_pass++;
    n_checks++; if (sat_o !== 1'b0) $display("FAIL rstmid sat_clear: got %b expected 0", sat_o); else n_pass++;
    @(negedge clk); s_tvalid = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    clear_q();
    push_pkt(p2, 2);
    run(4, 1'b0, 50);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (od_at(i) !== ex[i]) $display("FAIL rstmid beat%0d: got %h expected %h", i, od_at(i), ex[i]); else n_pass++;
    end
  endtask

  initial begin
    rstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0; stab_err = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_seq_wrap();
    test_len_sat();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
